wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Registered MEM/WB write-back stage for the pipelined MIPS core. Latches MEM-stage results,
//  selects the write-back source and drives the register-file write port one cycle later.
//  Selectable sources: ALU, memory, link PC, immediate. Adds stall/flush control, $0 write
//  suppression and a retired-instruction counter.
// PARAMETERS
//  DATA_W      32  datapath width (multiple of 8, >= 32)
//  REG_ADDR_W  5   register-file address width
//  CNT_W       32  retired-instruction counter width
// PORTS
//  clk           in   1           clock, all state updates on rising edge
//  rst           in   1           synchronous reset, active-high
//  stall         in   1           hold stage contents
//  flush         in   1           squash the instruction being latched
//  in_valid      in   1           MEM stage holds a real instruction
//  in_reg_write  in   1           instruction writes the register file
//  in_wb_sel     in   2           00 ALU, 01 mem, 10 link PC, 11 immediate
//  in_rd         in   REG_ADDR_W  destination register
//  in_alu        in   DATA_W      ALU result
//  in_mem        in   DATA_W      raw memory read word
//  in_link       in   DATA_W      PC+8 (PC+4 if no delay slot) for JAL/JALR
//  in_imm        in   DATA_W      immediate result (LUI)
//  in_size       in   2           load size: 00 byte, 01 half, 10 word
//  in_unsigned   in   1           zero-extend sub-word load
//  in_boff       in   2           byte offset of load address
//  rf_we         out  1           register-file write enable
//  rf_waddr      out  REG_ADDR_W  register-file write address
//  rf_wdata      out  DATA_W      register-file write data
//  wb_valid      out  1           stage holds a valid instruction
//  retired       out  CNT_W       count of instructions leaving the stage
// BEHAVIOUR
//  - Reset: all registered fields 0; rf_we=0, rf_waddr=0, rf_wdata=0, wb_valid=0, retired=0.
//  - Priority per edge: rst > flush > stall > load.
//  - Load: latch all in_* fields; wb_valid <= in_valid. Latency is exactly 1 cycle.
//  - flush (no rst): wb_valid <= 0; data fields may load but must not be written.
//  - stall (no flush, no rst): all fields and wb_valid hold.
//  - rf_we = wb_valid & reg_write_q & (rd_q != 0) & ~stall. A stalled instruction writes
//    only on the cycle it leaves. $0 is never written.
//  - rf_waddr = rd_q; rf_wdata = mux(wb_sel_q) over registered sources (combinational
//    from registers). rf_wdata and rf_waddr are don't-care when rf_we=0 but must not be X
//    after reset.
//  - retired += 1 on each edge with wb_valid=1 & ~stall & ~rst (incl. rd=0, no-write ops).
//    It wraps modulo 2^CNT_W.
//  - Simultaneous flush+stall: flush wins; the stalled instruction still retires/writes
//    this cycle. rst mid-stall discards the held instruction without a write.
//  - Unused in_wb_sel/in_size codes: 11 for size treated as word.
// CONFIGURATION
//  WB_LOAD_EXT_EN defined: for wb_sel=01, select the byte/half at in_boff (big-endian:
//    boff 0 = bits [31:24]; half uses boff[1]). Sign- or zero-extend per unsigned_q.
//  WB_LOAD_EXT_EN undefined: mem word passes unmodified. in_size, in_unsigned and in_boff
//    are ignored (not registered).
// TESTING
//  1 ALU op: in_valid=1, wb_sel=00, rd=5, alu=0x1234 -> next cycle rf_we=1, waddr=5,
//    wdata=0x1234, retired=1.
//  2 $0 guard: rd=0, reg_write=1, alu=0xFFFF -> rf_we=0 and retired still increments.
//  3 Stall then flush: load rd=7, stall 3 cycles -> rf_we=0, held. Release with flush=1 ->
//    rf_we=1 once for rd=7, then wb_valid=0.
//  4 JAL/LUI: wb_sel=10, link=0x0040_0008 -> wdata=0x0040_0008. wb_sel=11,
//    imm=0xABCD_0000 -> wdata=0xABCD_0000.
//  5 WB_LOAD_EXT_EN: mem=0x80FF_7F01, byte boff=0 signed -> 0xFFFF_FF80. Half boff=2
//    unsigned -> 0x0000_7F01. Macro off -> 0x80FF_7F01.
//  6 Reset mid-stream/wrap: assert rst while stalled -> no write, all outputs 0.
//    CNT_W=4 with 16 retirements -> retired wraps to 0.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB write-back stage; optional sub-word load extraction under WB_LOAD_EXT_EN
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_mem,
    input  logic [DATA_W-1:0]     in_link,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [1:0]            in_boff,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  wb_valid,
    output logic [CNT_W-1:0]      retired
);

    logic                  r_valid;
    logic                  r_reg_write;
    logic [1:0]            r_wb_sel;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_mem;
    logic [DATA_W-1:0]     r_link;
    logic [DATA_W-1:0]     r_imm;
    logic [CNT_W-1:0]      r_retired;

    logic                  w_load;
    logic                  w_leave;
    logic [DATA_W-1:0]     w_load_data;

    // Data fields capture on flush too; the cleared valid bit keeps them from writing.
    assign w_load  = flush | ~stall;
    // The held instruction leaves when the stage advances; flush overrides a stall.
    assign w_leave = r_valid & w_load;

    // Valid bit: reset, squash on flush, hold on stall, otherwise follow MEM stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid <= in_valid;
        end
    end

    // Payload registers: cleared on reset so write-port outputs are never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_wb_sel    <= 2'b00;
            r_rd        <= '0;
            r_alu       <= '0;
            r_mem       <= '0;
            r_link      <= '0;
            r_imm       <= '0;
        end else if (w_load) begin
            r_reg_write <= in_reg_write;
            r_wb_sel    <= in_wb_sel;
            r_rd        <= in_rd;
            r_alu       <= in_alu;
            r_mem       <= in_mem;
            r_link      <= in_link;
            r_imm       <= in_imm;
        end
    end

    // Retired-instruction counter, counts every leaving instruction and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_leave) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [1:0] r_size;
    logic       r_unsigned;
    logic [1:0] r_boff;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    // Load-shape fields travel with the rest of the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_boff     <= 2'b00;
        end else if (w_load) begin
            r_size     <= in_size;
            r_unsigned <= in_unsigned;
            r_boff     <= in_boff;
        end
    end

    // Big-endian lane pick and sign/zero extension; size 11 behaves as a word.
    always_comb begin
        w_byte      = r_mem[31:24];
        w_half      = r_boff[1] ? r_mem[15:0] : r_mem[31:16];
        w_load_data = r_mem;
        case (r_boff)
            2'd0:    w_byte = r_mem[31:24];
            2'd1:    w_byte = r_mem[23:16];
            2'd2:    w_byte = r_mem[15:8];
            default: w_byte = r_mem[7:0];
        endcase
        case (r_size)
            2'b00:   w_load_data = {{(DATA_W-8){~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{(DATA_W-16){~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = r_mem;
        endcase
    end
`else
    logic w_unused_ext;
    assign w_unused_ext = ^{in_size, in_unsigned, in_boff};
    assign w_load_data  = r_mem;
`endif

    // Write-back source select from registered operands.
    always_comb begin
        rf_wdata = r_alu;
        case (r_wb_sel)
            2'b00:   rf_wdata = r_alu;
            2'b01:   rf_wdata = w_load_data;
            2'b10:   rf_wdata = r_link;
            default: rf_wdata = r_imm;
        endcase
    end

    // A reset edge discards the instruction, so it must not write either.
    assign rf_we    = w_leave & r_reg_write & (r_rd != '0) & ~rst;
    assign rf_waddr = r_rd;
    assign wb_valid = r_valid;
    assign retired  = r_retired;

endmodule
